hazard_scoreboard: RTL
======================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL take parameter NREG, default 32: number of architectural GPRs; register 0 is hardwired zero.
REQ-002 The block SHALL take parameter AW, default 5: register address width, with 2^AW >= NREG.
REQ-003 The block SHALL take parameter TW, default 3: width of Tuse/Tnew countdown fields.
REQ-004 The block SHALL take parameter MUL_LAT, default 5: HI/LO busy cycles for a multiply.
REQ-005 The block SHALL take parameter DIV_LAT, default 10: HI/LO busy cycles for a divide; MUL_LAT and DIV_LAT SHALL each be < 2^8.
REQ-006 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- d_valid  in  1  D-stage holds a real instruction.
- d_rs, d_rt  in  AW  source register numbers.
- d_tuse_rs, d_tuse_rt  in  TW  cycles until the operand is needed; all-ones means unused.
- d_wr_en  in  1  instruction writes a GPR.
- d_wa  in  AW  destination register.
- d_tnew  in  TW  cycles after issue until the result is forwardable.
- d_md_start  in  1  instruction starts mult/div.
- d_md_div  in  1  with d_md_start: divide (else multiply).
- d_md_use  in  1  instruction touches HI/LO (md, mf*, mt*).
- flush  in  1  exception/eret pipeline flush.
- stall  out  1  hold F/D and bubble E.
- stall_rs, stall_rt, stall_md  out  1  individual causes.
- md_busy  out  1  HI/LO unit occupied.
- stall_cnt  out  32  saturating count of stalled cycles.

Function
REQ-007 The block SHALL define issue = d_valid & ~stall & ~flush.
REQ-008 The block SHALL keep one TW-bit countdown cnt[r] for each r in 1..NREG-1; cnt[0] SHALL read as 0 at all times.
REQ-009 Each cycle, every nonzero cnt[r] SHALL decrement by 1, except as REQ-010 and REQ-015 state.
REQ-010 On issue with d_wr_en=1 and d_wa!=0, cnt[d_wa] SHALL load d_tnew instead of decrementing, overriding any older pending value.
REQ-011 The block SHALL assert stall_rs combinationally when d_valid=1, d_rs!=0, d_tuse_rs != all-ones, and cnt[d_rs] > d_tuse_rs; stall_rt SHALL follow the same rule using d_rt and d_tuse_rt.
REQ-012 The block SHALL keep an 8-bit md_cnt; on issue with d_md_start=1 it SHALL load DIV_LAT when d_md_div=1, else MUL_LAT; otherwise a nonzero md_cnt SHALL decrement by 1.
REQ-013 The block SHALL drive md_busy = (md_cnt != 0), so busy begins the cycle after issue.
REQ-014 The block SHALL drive stall_md = d_valid & d_md_use & md_busy, and stall = stall_rs | stall_rt | stall_md.
REQ-015 When flush=1, on the next edge all cnt[r] and md_cnt SHALL clear to 0, no issue SHALL occur, and flush SHALL take priority over a simultaneous issue.
REQ-016 The block SHALL increment stall_cnt on every cycle with stall=1 and flush=0, and stall_cnt SHALL saturate at 0xFFFF_FFFF without wrapping.
REQ-017 While stall=1 the block SHALL change no cnt entry other than by decrement, so a stalled instruction is re-evaluated each cycle until the hazard clears.
REQ-018 stall, stall_rs, stall_rt and stall_md SHALL depend only on current inputs and registered state, with no path from stall back into the issue decision beyond REQ-007.

Reset
REQ-019 While rst_n=0, all cnt[r], md_cnt and stall_cnt SHALL be 0 asynchronously, so that stall, stall_rs, stall_rt, stall_md and md_busy all read 0.
REQ-020 Deassertion of rst_n mid-operation SHALL leave no pending hazard: the first instruction after reset SHALL issue without stall.

Verification
REQ-021 The bench SHALL cover load-use: issue lw to $8 with tnew=2, then present addu reading $8 with tuse_rs=1 -> stall=1 for exactly 1 cycle, then issue.
REQ-022 The bench SHALL cover a branch hazard: issue addu to $9 with tnew=1, then present beq on $9 with tuse=0 -> stall for 1 cycle; with lw (tnew=2) in place of addu -> stall for 2 cycles.
REQ-023 The bench SHALL cover register 0 and unused operands: write to $0 with tnew=2, then read $0 -> no stall; d_tuse_rt=7 with a pending $rt -> no stall_rt.
REQ-024 The bench SHALL cover mult/div occupancy: issue div (DIV_LAT=10), then present mfhi the next cycle -> stall_md=1 for 10 cycles; issuing an ordinary addu in the meantime -> no stall.
REQ-025 The bench SHALL cover flush: issue lw to $8 (tnew=2) and start mult, then flush=1 with d_valid=1 in the same cycle -> no issue; next cycle cnt cleared, md_busy=0, and a reader of $8 issues without stall.
REQ-026 The bench SHALL cover counter behaviour: hold a hazard for 5 cycles -> stall_cnt=5; then force stall_cnt to 0xFFFF_FFFE and stall for 3 cycles -> stall_cnt=0xFFFF_FFFF; async rst_n=0 mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage interlock for an in-order MIPS-style pipeline.
// Each GPR has a countdown of cycles until its pending result becomes
// forwardable. A D-stage operand stalls while that countdown exceeds the
// operand's own Tuse. A separate occupancy counter tracks the HI/LO
// multiply/divide unit. A saturating counter records the total number of stalled cycles.
module hazard_scoreboard #(
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int TW      = 3,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          d_valid,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic          d_wr_en,
    input  logic [AW-1:0] d_wa,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_md_start,
    input  logic          d_md_div,
    input  logic          d_md_use,
    input  logic          flush,
    output logic          stall,
    output logic          stall_rs,
    output logic          stall_rt,
    output logic          stall_md,
    output logic          md_busy,
    output logic [31:0]   stall_cnt
);

    localparam int            NSLOT     = 1 << AW;
    localparam logic [TW-1:0] TUSE_NONE = '1;
    localparam logic [7:0]    MUL_CYC   = 8'(MUL_LAT);
    localparam logic [7:0]    DIV_CYC   = 8'(DIV_LAT);

    // Countdown per addressable slot; slot 0 and slots beyond NREG read as 0.
    logic [TW-1:0] cnt_view [NSLOT];
    logic [7:0]    md_cnt_q, md_cnt_d;
    logic [31:0]   stall_cnt_q, stall_cnt_d;
    logic          issue;

    // Stall causes come only from inputs and registered state; issue is
    // the only consumer of stall, so there is no combinational loop.
    assign stall_rs = d_valid && (d_rs != '0) && (d_tuse_rs != TUSE_NONE)
                      && (cnt_view[d_rs] > d_tuse_rs);
    assign stall_rt = d_valid && (d_rt != '0) && (d_tuse_rt != TUSE_NONE)
                      && (cnt_view[d_rt] > d_tuse_rt);
    assign md_busy  = (md_cnt_q != '0);
    assign stall_md = d_valid && d_md_use && md_busy;
    assign stall    = stall_rs || stall_rt || stall_md;
    assign issue    = d_valid && !stall && !flush;
    assign stall_cnt = stall_cnt_q;

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            if (gi == 0 || gi >= NREG) begin : g_zero
                assign cnt_view[gi] = '0;
            end else begin : g_reg
                logic [TW-1:0] cnt_q, cnt_d;

                // Flush clears, a new writer overrides, otherwise count down to 0.
                always_comb begin
                    cnt_d = cnt_q;
                    if (flush) begin
                        cnt_d = '0;
                    end else if (issue && d_wr_en && (d_wa == AW'(gi))) begin
                        cnt_d = d_tnew;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - TW'(1);
                    end
                end

                // Per-register countdown state.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                assign cnt_view[gi] = cnt_q;
            end
        end
    endgenerate

    // HI/LO occupancy: reload on a started mult/div, otherwise drain.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (flush) begin
            md_cnt_d = '0;
        end else if (issue && d_md_start) begin
            md_cnt_d = d_md_div ? DIV_CYC : MUL_CYC;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 8'd1;
        end
    end

    // Stalled-cycle counter; flushed cycles are not counted and it never wraps.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Shared state registers for the HI/LO and statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
